// File: rtl/cpu_pkg.sv
// Shared types, encodings and helpers for the multicycle ARM-subset core.
package cpu_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StAluWb, StMemAdr,
    StMemRd, StMemWb, StMemWr, StBranch, StHalt
  } state_t;

  typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOrr} alu_op_t;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // NV is screened out as undefined before this is consulted.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FlagN];
    z = nzcv[FlagZ];
    c = nzcv[FlagC];
    v = nzcv[FlagV];
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = !c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = c && !z;
      4'h9:    cond_pass = !c || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface cpu_multicycle_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_alu.sv
// 32-bit ALU: ADD/SUB/AND/ORR with NZCV; logical ops clear C and V.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);
  logic        is_sub;
  logic        is_arith;
  logic [31:0] b_eff;
  logic [32:0] sum;

  always_comb begin
    is_sub   = (op == AluSub);
    is_arith = (op == AluAdd) || is_sub;
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'h0, is_sub};
    result   = sum[31:0];
    case (op)
      AluAnd:  result = a & b;
      AluOrr:  result = a | b;
      default: result = sum[31:0];
    endcase
    nzcv[FlagN] = result[31];
    nzcv[FlagZ] = (result == 32'h0);
    nzcv[FlagC] = is_arith & sum[32];
    // Overflow: operands (after inversion for SUB) agree in sign but result differs.
    nzcv[FlagV] = is_arith & (a[31] == b_eff[31]) & (result[31] != a[31]);
  end
endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle ARM-subset core (DP, LDR/STR, B) on one stallable memory port.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  cpu_multicycle_if.master  mem,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              retire,
  output logic              halted
);
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        flags_q;
  logic              halted_q;
  logic [31:0]       instr_q, a_q, b_q, wd_q, res_q, data_q;
  logic [3:0]        nzcv_q;
  logic [31:0]       rf_q [15];

  logic [3:0]  cond, cmd, rn, rd;
  logic [1:0]  op;
  logic        imm_i, set_s, up, load, is_cmp, undef, pass, mem_done;
  logic [31:0] pc_plus8, rn_val, rd_val, rm_val, src2, br_off, alu_res;
  logic [3:0]  alu_nzcv;
  alu_op_t     alu_op;
  logic [ADDR_W-1:0] br_target;

  assign cond   = instr_q[31:28];
  assign op     = instr_q[27:26];
  assign imm_i  = instr_q[25];
  assign cmd    = instr_q[24:21];
  assign up     = instr_q[23];
  assign set_s  = instr_q[20];
  assign load   = instr_q[20];
  assign rn     = instr_q[19:16];
  assign rd     = instr_q[15:12];
  assign is_cmp = (cmd == CmdCmp);

  // pc_q already points past the instruction, so R15 = pc_q + 4.
  assign pc_plus8  = 32'(pc_q + ADDR_W'(4));
  assign rn_val    = (rn == 4'd15) ? pc_plus8 : rf_q[rn];
  assign rd_val    = (rd == 4'd15) ? pc_plus8 : rf_q[rd];
  assign rm_val    = (instr_q[3:0] == 4'd15) ? pc_plus8 : rf_q[instr_q[3:0]];
  assign src2      = imm_i ? {24'h0, instr_q[7:0]} : rm_val;
  assign br_off    = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
  assign br_target = ADDR_W'(pc_plus8 + br_off);
  assign pass      = cond_pass(cond, flags_q);
  assign mem_done  = mem.mem_req && mem.mem_ready;

  always_comb begin
    undef = 1'b0;
    case (op)
      OpDp: undef = !(cmd inside {CmdAnd, CmdSub, CmdAdd, CmdOrr, CmdCmp}) ||
                    (!imm_i && instr_q[11:4] != 8'h0) || (rd == 4'd15 && !is_cmp);
      OpMem: undef = instr_q[25] || !instr_q[24] || instr_q[22] || instr_q[21] ||
                     (load && rd == 4'd15);
      OpBr: undef = 1'b0;
      default: undef = 1'b1;
    endcase
    if (cond == CondNv) undef = 1'b1;
  end

  always_comb begin
    alu_op = AluAdd;
    if (state_q == StMemAdr) begin
      alu_op = up ? AluAdd : AluSub;
    end else begin
      case (cmd)
        CmdAnd:         alu_op = AluAnd;
        CmdOrr:         alu_op = AluOrr;
        CmdSub, CmdCmp: alu_op = AluSub;
        default:        alu_op = AluAdd;
      endcase
    end
  end

  cpu_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (alu_op),
    .result (alu_res),
    .nzcv   (alu_nzcv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= ADDR_W'(RESET_PC);
      flags_q  <= 4'h0;
      halted_q <= 1'b0;
      instr_q  <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      wd_q     <= 32'h0;
      res_q    <= 32'h0;
      data_q   <= 32'h0;
      nzcv_q   <= 4'h0;
      for (int i = 0; i < 15; i++) rf_q[i] <= 32'h0;
    end else begin
      unique case (state_q)
        StFetch: if (mem_done) begin
          instr_q <= mem.mem_rdata;
          pc_q    <= pc_q + ADDR_W'(4);
          state_q <= StDecode;
        end
        StDecode: begin
          a_q  <= rn_val;
          b_q  <= (op == OpMem) ? {20'h0, instr_q[11:0]} : src2;
          wd_q <= rd_val;
          if (undef) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (!pass)       state_q <= StFetch;
          else if (op == OpDp)      state_q <= StExec;
          else if (op == OpMem)     state_q <= StMemAdr;
          else                      state_q <= StBranch;
        end
        StExec: begin
          res_q   <= alu_res;
          nzcv_q  <= alu_nzcv;
          state_q <= StAluWb;
        end
        StAluWb: begin
          if (!is_cmp)         rf_q[rd] <= res_q;
          if (set_s || is_cmp) flags_q  <= nzcv_q;
          state_q <= StFetch;
        end
        StMemAdr: begin
          res_q   <= alu_res;
          state_q <= load ? StMemRd : StMemWr;
        end
        StMemRd: if (mem_done) begin
          data_q  <= mem.mem_rdata;
          state_q <= StMemWb;
        end
        StMemWb: begin
          rf_q[rd] <= data_q;
          state_q  <= StFetch;
        end
        StMemWr:  if (mem_done) state_q <= StFetch;
        StBranch: begin
          pc_q    <= br_target;
          state_q <= StFetch;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  // Bus outputs decode the registered state; reset forces the port idle at once.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = 32'h0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = pc_q;
        end
        StMemRd: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = {res_q[ADDR_W-1:2], 2'b00};
        end
        StMemWr: begin
          mem.mem_req   = 1'b1;
          mem.mem_we    = 1'b1;
          mem.mem_addr  = {res_q[ADDR_W-1:2], 2'b00};
          mem.mem_wdata = wd_q;
        end
        default: ;
      endcase
    end
  end

  assign retire = !rst && ((state_q == StAluWb) || (state_q == StMemWb) ||
                           (state_q == StBranch) || (state_q == StMemWr && mem.mem_ready) ||
                           (state_q == StDecode && !undef && !pass));
  assign pc     = pc_q;
  assign flags  = flags_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: vector table plus handshake/branch/halt/reset sequences.
module tb_cpu_multicycle;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        retire;
  logic        halted;

  cpu_multicycle_if #(.ADDR_W(16)) bus ();

  cpu_multicycle #(.ADDR_W(16), .RESET_PC(32'h0100)) dut (
    .clk    (clk),
    .rst    (rst),
    .mem    (bus),
    .pc     (pc),
    .flags  (flags),
    .retire (retire),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Program memory at 0x100.., data memory below 0x100 with its own wait count.
  logic [31:0] pmem [64];
  logic [31:0] dmem [64];
  int fetch_wait = 0, data_wait = 0, cur_wait;
  int len_cur = 0, last_len = 0, cyc = 0, ret_cnt = 0, last_ret = 0, wr_cnt = 0;
  logic [15:0] wr_addr = '0, h_addr = '0, poff;
  logic [31:0] wr_data = '0, h_wdata = '0;
  logic        h_we = 1'b0, held = 1'b0, unstable = 1'b0;

  always_comb begin
    poff     = bus.mem_addr - 16'h0100;
    cur_wait = (bus.mem_addr < 16'h0100) ? data_wait : fetch_wait;
    bus.mem_ready = bus.mem_req && (len_cur >= cur_wait);
    if (bus.mem_addr < 16'h0100) bus.mem_rdata = dmem[bus.mem_addr[7:2]];
    else                         bus.mem_rdata = pmem[poff[7:2]];
  end

  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0; ret_cnt <= 0; len_cur <= 0; held <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (retire) begin
        ret_cnt  <= ret_cnt + 1;
        last_ret <= cyc + 1;
      end
      if (bus.mem_req) begin
        if (held && (bus.mem_addr != h_addr || bus.mem_we != h_we || bus.mem_wdata != h_wdata))
          unstable <= 1'b1;
        if (bus.mem_ready) begin
          last_len <= len_cur + 1;
          len_cur  <= 0;
          held     <= 1'b0;
          if (bus.mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
            if (bus.mem_addr < 16'h0100) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
          end
        end else begin
          len_cur <= len_cur + 1;
          held    <= 1'b1;
          h_addr  <= bus.mem_addr;
          h_we    <= bus.mem_we;
          h_wdata <= bus.mem_wdata;
        end
      end
    end
  end

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_pmem();
    for (int i = 0; i < 64; i++) pmem[i] = 32'hEAFF_FFFE;  // B . (self loop)
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_ret(input int target, input string name);
    int n = 0;
    while (ret_cnt < target && n < 200) begin
      @(negedge clk); n++;
    end
    if (ret_cnt < target) begin
      n_chk++;
      $display("FAIL %s: retire timeout, got %0d retires expected %0d", name, ret_cnt, target);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] val;
    logic [3:0]  nzcv;
    int          lat;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] undefs [7];
  int prev;
  logic req_seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vecs[0]  = '{32'hE280_1005, 1, 32'h0000_0005, 4'b0000, 4};  // ADD  R1,R0,#5
    vecs[1]  = '{32'hE251_2005, 2, 32'h0000_0000, 4'b0110, 4};  // SUBS R2,R1,#5
    vecs[2]  = '{32'hE252_3001, 3, 32'hFFFF_FFFF, 4'b1000, 4};  // SUBS R3,R2,#1
    vecs[3]  = '{32'hE293_4001, 4, 32'h0000_0000, 4'b0110, 4};  // ADDS R4,R3,#1
    vecs[4]  = '{32'hE381_50A0, 5, 32'h0000_00A5, 4'b0110, 4};  // ORR  R5,R1,#0xA0
    vecs[5]  = '{32'hE015_6001, 6, 32'h0000_0005, 4'b0000, 4};  // ANDS R6,R5,R1
    vecs[6]  = '{32'hE28F_7000, 7, 32'h0000_0120, 4'b0000, 4};  // ADD  R7,R15,#0
    vecs[7]  = '{32'hE093_8003, 8, 32'hFFFF_FFFE, 4'b1010, 4};  // ADDS R8,R3,R3
    vecs[8]  = '{32'hE351_0005, 0, 32'h0000_0000, 4'b0110, 4};  // CMP  R1,#5
    vecs[9]  = '{32'h1280_9001, 9, 32'h0000_0000, 4'b0110, 2};  // ADDNE (fails)
    vecs[10] = '{32'h0280_9007, 9, 32'h0000_0007, 4'b0110, 4};  // ADDEQ R9,R0,#7
    undefs[0] = 32'hEC00_0000;  // op = 11
    undefs[1] = 32'hE28F_F000;  // ADD R15
    undefs[2] = 32'hE2C0_1000;  // unsupported cmd
    undefs[3] = 32'hE5A0_1008;  // W = 1
    undefs[4] = 32'hF280_1005;  // cond NV
    undefs[5] = 32'hE080_1011;  // nonzero shift field
    undefs[6] = 32'hE590_F008;  // LDR R15

    // Reset state and first fetch, then the DP vector table.
    clear_pmem();
    for (int i = 0; i < 11; i++) pmem[i] = vecs[i].instr;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_retire", {31'h0, retire}, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req", {31'h0, bus.mem_req}, 32'h1);
    chk("first_addr", {16'h0, bus.mem_addr}, 32'h0100);
    chk("first_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    prev = 0;
    for (int i = 0; i < 11; i++) begin
      wait_ret(i + 1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_lat", i), last_ret - prev, vecs[i].lat);
      prev = last_ret;
      chk($sformatf("vec%0d_reg", i), dut.rf_q[vecs[i].rd], vecs[i].val);
      chk($sformatf("vec%0d_flags", i), {28'h0, flags}, {28'h0, vecs[i].nzcv});
    end

    // STR then LDR with 3 wait cycles on each data access.
    clear_pmem();
    pmem[0] = 32'hE280_1005;  // ADD R1,R0,#5
    pmem[1] = 32'hE580_1008;  // STR R1,[R0,#8]
    pmem[2] = 32'hE590_3008;  // LDR R3,[R0,#8]
    data_wait = 3;
    do_reset();
    wait_ret(1, "mem_add");
    prev = last_ret;
    wait_ret(2, "str");
    chk("str_lat", last_ret - prev, 7);
    chk("str_hold", last_len, 4);
    chk("str_addr", {16'h0, wr_addr}, 32'h8);
    chk("str_data", wr_data, 32'h5);
    prev = last_ret;
    wait_ret(3, "ldr");
    chk("ldr_lat", last_ret - prev, 8);
    chk("ldr_hold", last_len, 4);
    chk("ldr_r3", dut.rf_q[3], 32'h5);
    data_wait = 0;

    // CMP; BNE not taken; BEQ to itself.
    clear_pmem();
    pmem[0] = 32'hE280_1005;  // ADD R1,R0,#5
    pmem[1] = 32'hE351_0005;  // CMP R1,#5
    pmem[2] = 32'h1A00_0002;  // BNE +8
    pmem[3] = 32'h0AFF_FFFE;  // BEQ -2 words
    do_reset();
    wait_ret(2, "br_cmp");
    prev = last_ret;
    wait_ret(3, "bne");
    chk("bne_lat", last_ret - prev, 2);
    chk("bne_next", {16'h0, bus.mem_addr}, 32'h010C);
    prev = last_ret;
    wait_ret(4, "beq");
    chk("beq_lat", last_ret - prev, 3);
    chk("beq_target", {16'h0, bus.mem_addr}, 32'h010C);
    chk("beq_pc", {16'h0, pc}, 32'h010C);

    // Undefined encodings halt and stop all bus traffic.
    for (int u = 0; u < 7; u++) begin
      clear_pmem();
      pmem[0] = undefs[u];
      do_reset();
      @(negedge clk);
      chk($sformatf("undef%0d_pre", u), {31'h0, halted}, 32'h0);
      @(negedge clk);
      chk($sformatf("undef%0d_halt", u), {31'h0, halted}, 32'h1);
      req_seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (bus.mem_req) req_seen = 1'b1;
      end
      chk($sformatf("undef%0d_noreq", u), {31'h0, req_seen}, 32'h0);
      chk($sformatf("undef%0d_noret", u), ret_cnt, 0);
    end
    do_reset();
    #1;
    chk("halt_cleared", {31'h0, halted}, 32'h0);

    // Reset while a store is stalled.
    clear_pmem();
    pmem[0] = 32'hE280_1005;  // ADD R1,R0,#5
    pmem[1] = 32'hE580_100C;  // STR R1,[R0,#12]
    data_wait = 1000;
    do_reset();
    prev = wr_cnt;
    for (int n = 0; n < 30 && !(bus.mem_req && bus.mem_we); n++) @(negedge clk);
    chk("wr_reached", {31'h0, bus.mem_req && bus.mem_we}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwr_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rstwr_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rstwr_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("rstwr_wdata", bus.mem_wdata, 32'h0);
    chk("rstwr_retire", {31'h0, retire}, 32'h0);
    @(negedge clk);
    chk("rstwr_pc", {16'h0, pc}, 32'h0100);
    chk("rstwr_req2", {31'h0, bus.mem_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rstwr_fetch", {16'h0, bus.mem_addr}, 32'h0100);
    chk("rstwr_nowrite", wr_cnt, prev);
    data_wait = 0;

    chk("bus_stable", {31'h0, unstable}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
